// File: rtl/cpu_pkg.sv
// Shared definitions for the yIF/yID/yEX/yDM/yWB datapath control:
// opcode constants, sequencer state encodings and PC source select codes.
package cpu_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_BAD    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PC_P4    = 2'd0,
    PC_BR    = 2'd1,
    PC_JAL   = 2'd2,
    PC_ENTRY = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/yC1.sv
// Opcode classifier: one flag per supported instruction class.
// An opcode matching none of the classes is treated as unknown by the caller.
module yC1
  import cpu_pkg::*;
(
  output logic       isStype,
  output logic       isRtype,
  output logic       isItype,
  output logic       isLw,
  output logic       isjump,
  output logic       isbranch,
  input  logic [6:0] opCode
);

  assign isStype  = (opCode == OP_SW);
  assign isRtype  = (opCode == OP_R);
  assign isItype  = (opCode == OP_I);
  assign isLw     = (opCode == OP_LW);
  assign isjump   = (opCode == OP_JAL);
  assign isbranch = (opCode == OP_BEQ);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: walks each instruction through fetch/decode/exec/mem/wb,
// generating per-phase strobes, memory wait states, retire counting and halt/restart.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_INSN = 43,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             INT,
  input  logic [XLEN-1:0]  entryPoint,
  input  logic [6:0]       opCode,
  input  logic             zero,
  output logic             pcWrite,
  output logic [1:0]       pcSel,
  output logic             irWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             RegWrite,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] insCount,
  output logic             halted,
  output logic             illegal
);

  localparam int WAIT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(MAX_INSN);

  state_t            st_q, st_d;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cnt_q, cnt_inc;
  logic              illegal_q, int_pend;
  logic              last, retire, cnt_clear, set_ill, clr_ill, int_ack;
  logic              pc_write, ir_write, mem_read, mem_write, reg_write;
  pc_sel_t           pc_sel;
  logic              is_s, is_r, is_i, is_lw, is_j, is_b;

  // The PC mux lives in the datapath; the entry point is only carried through here.
  logic unused_entry;
  assign unused_entry = ^entryPoint;

  yC1 u_yc1 (
    .isStype (is_s),
    .isRtype (is_r),
    .isItype (is_i),
    .isLw    (is_lw),
    .isjump  (is_j),
    .isbranch(is_b),
    .opCode  (opCode)
  );

  assign last    = (wait_q == WAIT_LAST);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    st_d      = st_q;
    pc_write  = 1'b0;
    pc_sel    = PC_P4;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    retire    = 1'b0;
    cnt_clear = 1'b0;
    set_ill   = 1'b0;
    clr_ill   = 1'b0;
    int_ack   = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        pc_write  = 1'b1;
        pc_sel    = PC_ENTRY;
        cnt_clear = 1'b1;
        st_d      = ST_FETCH;
      end
      ST_FETCH: begin
        mem_read = 1'b1;
        if (last) begin
          ir_write = 1'b1;
          st_d     = ST_DECODE;
        end
      end
      ST_DECODE: st_d = ST_EXEC;
      ST_EXEC: begin
        if (is_r || is_i || is_j) begin
          st_d = ST_WB;
        end else if (is_lw || is_s) begin
          st_d = ST_MEM;
        end else if (is_b) begin
          retire   = 1'b1;
          pc_write = 1'b1;
          pc_sel   = zero ? PC_BR : PC_P4;
        end else begin
          set_ill = 1'b1;
          st_d    = ST_HALT;
        end
      end
      ST_MEM: begin
        if (is_s) begin
          if (last) begin
            mem_write = 1'b1;
            pc_write  = 1'b1;
            retire    = 1'b1;
          end
        end else begin
          mem_read = 1'b1;
          if (last) st_d = ST_WB;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        pc_sel    = is_j ? PC_JAL : PC_P4;
        retire    = 1'b1;
      end
      default: begin
        // HALT, and the unreachable encoding 7 which behaves identically.
        if (INT || int_pend) begin
          st_d      = ST_IDLE;
          clr_ill   = 1'b1;
          cnt_clear = 1'b1;
          int_ack   = 1'b1;
        end
      end
    endcase

    // A pending interrupt redirects the retire to the entry point and skips the halt check.
    if (retire) begin
      if (int_pend) begin
        pc_sel    = PC_ENTRY;
        cnt_clear = 1'b1;
        int_ack   = 1'b1;
        st_d      = ST_FETCH;
      end else if (MAX_INSN != 0 && cnt_inc == LIMIT) begin
        st_d = ST_HALT;
      end else begin
        st_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= ST_IDLE;
      wait_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      int_pend  <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_d == st_q && (st_q == ST_FETCH || st_q == ST_MEM)) wait_q <= wait_q + 1'b1;
      else                                                      wait_q <= '0;
      if (cnt_clear)   cnt_q <= '0;
      else if (retire) cnt_q <= cnt_inc;
      if (set_ill)      illegal_q <= 1'b1;
      else if (clr_ill) illegal_q <= 1'b0;
      if (int_ack)  int_pend <= 1'b0;
      else if (INT) int_pend <= 1'b1;
    end
  end

  // Strobes are forced low while reset is held so IDLE's PC load cannot leak out.
  assign pcWrite  = pc_write  & ~reset;
  assign pcSel    = reset ? '0 : pc_sel;
  assign irWrite  = ir_write  & ~reset;
  assign memRead  = mem_read  & ~reset;
  assign memWrite = mem_write & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign state    = st_q;
  assign insCount = cnt_q;
  assign halted   = (st_q == ST_HALT) || (st_q == ST_BAD);
  assign illegal  = illegal_q || (st_q == ST_BAD);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: unit 0 has one wait state and a 3-insn halt limit,
// unit 1 has three wait states and runs forever.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, irq, zf;
  logic [1:0][6:0]  op;
  logic [31:0]      entry = 32'h28;
  logic [1:0]       pw, ir, mr, mw, rw, hlt, ill;
  logic [1:0][1:0]  ps;
  logic [1:0][2:0]  st;
  logic [1:0][15:0] cnt;
  logic [1:0][9:0]  obs;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.XLEN(32), .MEM_LAT(1), .MAX_INSN(3), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst[0]), .INT(irq[0]), .entryPoint(entry), .opCode(op[0]),
    .zero(zf[0]), .pcWrite(pw[0]), .pcSel(ps[0]), .irWrite(ir[0]), .memRead(mr[0]),
    .memWrite(mw[0]), .RegWrite(rw[0]), .state(st[0]), .insCount(cnt[0]),
    .halted(hlt[0]), .illegal(ill[0])
  );

  multicycle_ctrl #(.XLEN(32), .MEM_LAT(3), .MAX_INSN(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(rst[1]), .INT(irq[1]), .entryPoint(entry), .opCode(op[1]),
    .zero(zf[1]), .pcWrite(pw[1]), .pcSel(ps[1]), .irWrite(ir[1]), .memRead(mr[1]),
    .memWrite(mw[1]), .RegWrite(rw[1]), .state(st[1]), .insCount(cnt[1]),
    .halted(hlt[1]), .illegal(ill[1])
  );

  assign obs[0] = {pw[0], ps[0], ir[0], mr[0], mw[0], rw[0], st[0]};
  assign obs[1] = {pw[1], ps[1], ir[1], mr[1], mw[1], rw[1], st[1]};

  function automatic logic [9:0] ev(input int pw_e, input int ps_e, input int ir_e,
                                    input int mr_e, input int mw_e, input int rw_e,
                                    input int st_e);
    return {pw_e[0], ps_e[1:0], ir_e[0], mr_e[0], mw_e[0], rw_e[0], st_e[2:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int u, input logic [9:0] exp, input string tag);
    @(posedge clk);
    #2;
    check(tag, 32'(obs[u]), 32'(exp));
  endtask

  // Opcode for the next instruction is loaded once the previous one has left its last state.
  task automatic fetch(input int u, input int n, input logic [6:0] nop);
    for (int i = 0; i < n; i++) begin
      step(u, ev(0, 0, (i == n - 1) ? 1 : 0, 1, 0, 0, 1), "fetch");
      if (i == 0) op[u] = nop;
    end
  endtask

  initial begin
    rst = 2'b11; irq = '0; zf = '0;
    op[0] = 7'h33; op[1] = 7'h23;
    repeat (2) @(posedge clk);
    #2;
    check("rst_outs", 32'(obs[0]), 32'h0);
    check("rst_cnt", 32'(cnt[0]), 32'h0);
    check("rst_flags", 32'({hlt[0], ill[0]}), 32'h0);

    // unit 0: R-type, beq taken, beq not taken -> halt limit
    rst[0] = 1'b0;
    #1;
    check("idle", 32'(obs[0]), 32'(ev(1, 3, 0, 0, 0, 0, 0)));
    fetch(0, 2, 7'h33);
    step(0, ev(0, 0, 0, 0, 0, 0, 2), "r_dec");
    step(0, ev(0, 0, 0, 0, 0, 0, 3), "r_exec");
    step(0, ev(1, 0, 0, 0, 0, 1, 5), "r_wb");
    check("r_cnt_before", 32'(cnt[0]), 32'd0);
    fetch(0, 2, 7'h63);
    check("r_cnt_after", 32'(cnt[0]), 32'd1);
    zf[0] = 1'b1;
    step(0, ev(0, 0, 0, 0, 0, 0, 2), "beq_dec");
    step(0, ev(1, 1, 0, 0, 0, 0, 3), "beq_taken");
    fetch(0, 2, 7'h63);
    zf[0] = 1'b0;
    check("beq_cnt", 32'(cnt[0]), 32'd2);
    step(0, ev(0, 0, 0, 0, 0, 0, 2), "beq2_dec");
    step(0, ev(1, 0, 0, 0, 0, 0, 3), "beq_not_taken");
    step(0, ev(0, 0, 0, 0, 0, 0, 6), "halt_limit");
    check("halt_cnt", 32'(cnt[0]), 32'd3);
    check("halt_flag", 32'(hlt[0]), 32'd1);
    step(0, ev(0, 0, 0, 0, 0, 0, 6), "halt_stays");

    // restart from halt
    irq[0] = 1'b1;
    step(0, ev(1, 3, 0, 0, 0, 0, 0), "restart_idle");
    irq[0] = 1'b0;
    check("restart_cnt", 32'(cnt[0]), 32'd0);
    check("restart_hlt", 32'(hlt[0]), 32'd0);

    // lw with interrupt raised during MEM
    fetch(0, 2, 7'h03);
    step(0, ev(0, 0, 0, 0, 0, 0, 2), "lw_dec");
    step(0, ev(0, 0, 0, 0, 0, 0, 3), "lw_exec");
    step(0, ev(0, 0, 0, 1, 0, 0, 4), "lw_mem0");
    irq[0] = 1'b1;
    step(0, ev(0, 0, 0, 1, 0, 0, 4), "lw_mem1");
    irq[0] = 1'b0;
    step(0, ev(1, 3, 0, 0, 0, 1, 5), "lw_wb_int");
    fetch(0, 2, 7'h7F);
    check("int_cnt", 32'(cnt[0]), 32'd0);

    // unknown opcode
    step(0, ev(0, 0, 0, 0, 0, 0, 2), "ill_dec");
    step(0, ev(0, 0, 0, 0, 0, 0, 3), "ill_exec");
    step(0, ev(0, 0, 0, 0, 0, 0, 6), "ill_halt");
    check("ill_flags", 32'({hlt[0], ill[0]}), 32'h3);
    check("ill_cnt", 32'(cnt[0]), 32'd0);
    irq[0] = 1'b1;
    step(0, ev(1, 3, 0, 0, 0, 0, 0), "ill_restart");
    irq[0] = 1'b0;
    check("ill_cleared", 32'(ill[0]), 32'd0);

    // reset in the middle of a fetch
    fetch(0, 2, 7'h33);
    step(0, ev(0, 0, 0, 0, 0, 0, 2), "r2_dec");
    step(0, ev(0, 0, 0, 0, 0, 0, 3), "r2_exec");
    step(0, ev(1, 0, 0, 0, 0, 1, 5), "r2_wb");
    step(0, ev(0, 0, 0, 1, 0, 0, 1), "r2_fetch0");
    check("r2_cnt", 32'(cnt[0]), 32'd1);
    rst[0] = 1'b1;
    #1;
    check("midrst_outs", 32'(obs[0]), 32'h0);
    check("midrst_cnt", 32'(cnt[0]), 32'h0);
    check("midrst_flags", 32'({hlt[0], ill[0]}), 32'h0);
    step(0, ev(0, 0, 0, 0, 0, 0, 0), "midrst_held");

    // unit 1: sw, lw, jal with three wait states
    rst[1] = 1'b0;
    #1;
    check("b_idle", 32'(obs[1]), 32'(ev(1, 3, 0, 0, 0, 0, 0)));
    fetch(1, 4, 7'h23);
    step(1, ev(0, 0, 0, 0, 0, 0, 2), "sw_dec");
    step(1, ev(0, 0, 0, 0, 0, 0, 3), "sw_exec");
    for (int i = 0; i < 3; i++) step(1, ev(0, 0, 0, 0, 0, 0, 4), "sw_mem_wait");
    step(1, ev(1, 0, 0, 0, 1, 0, 4), "sw_mem_last");
    fetch(1, 4, 7'h03);
    check("sw_cnt", 32'(cnt[1]), 32'd1);
    step(1, ev(0, 0, 0, 0, 0, 0, 2), "lw_b_dec");
    step(1, ev(0, 0, 0, 0, 0, 0, 3), "lw_b_exec");
    for (int i = 0; i < 4; i++) step(1, ev(0, 0, 0, 1, 0, 0, 4), "lw_b_mem");
    step(1, ev(1, 0, 0, 0, 0, 1, 5), "lw_b_wb");
    fetch(1, 4, 7'h6F);
    check("lw_b_cnt", 32'(cnt[1]), 32'd2);
    step(1, ev(0, 0, 0, 0, 0, 0, 2), "jal_dec");
    step(1, ev(0, 0, 0, 0, 0, 0, 3), "jal_exec");
    step(1, ev(1, 2, 0, 0, 0, 1, 5), "jal_wb");
    step(1, ev(0, 0, 0, 1, 0, 0, 1), "jal_next_fetch");
    check("jal_cnt", 32'(cnt[1]), 32'd3);
    check("b_no_halt", 32'(hlt[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
